// File: rtl/student_fir_ch_scheduler.sv
// Shares one FIR datapath between the left and right channels of a stereo frame.
// Frames arriving while a frame is in flight are dropped and counted; a hung FIR is timed out.
module student_fir_ch_scheduler #(
  parameter int DATA_SIZE      = 16,
  parameter int Y_WIDTH        = 27,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_strobe_i,
  input  logic [DATA_SIZE-1:0] sample_l_i,
  input  logic [DATA_SIZE-1:0] sample_r_i,
  input  logic [1:0]           ch_en_i,
  output logic                 fir_valid_strobe_o,
  output logic [DATA_SIZE-1:0] fir_sample_o,
  output logic                 fir_ch_o,
  input  logic                 fir_valid_strobe_i,
  input  logic [Y_WIDTH-1:0]   fir_y_i,
  output logic                 valid_strobe_o,
  output logic [Y_WIDTH-1:0]   y_l_o,
  output logic [Y_WIDTH-1:0]   y_r_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] overrun_cnt_o,
  output logic [CNT_WIDTH-1:0] timeout_cnt_o
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, ISSUE_L, WAIT_L, ISSUE_R, WAIT_R, OUT} state_t;

  state_t               state_reg;
  logic [DATA_SIZE-1:0] sample_r_reg;
  logic                 en_r_reg;
  logic [Y_WIDTH-1:0]   y_l_reg;
  logic [WAIT_W-1:0]    wait_cnt_reg;

  logic               in_wait;
  logic               wait_expired;
  logic               wait_end;
  logic               timeout_hit;
  logic [Y_WIDTH-1:0] wait_result;

  // A FIR done on the expiry cycle takes precedence over the timeout.
  assign in_wait      = (state_reg == WAIT_L) || (state_reg == WAIT_R);
  assign wait_expired = (wait_cnt_reg == WAIT_LAST);
  assign wait_end     = fir_valid_strobe_i || wait_expired;
  assign timeout_hit  = in_wait && !fir_valid_strobe_i && wait_expired;
  assign wait_result  = fir_valid_strobe_i ? fir_y_i : '0;

  // Outputs are registered and set on state entry so they line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg          <= IDLE;
      sample_r_reg       <= '0;
      en_r_reg           <= 1'b0;
      y_l_reg            <= '0;
      wait_cnt_reg       <= '0;
      fir_valid_strobe_o <= 1'b0;
      fir_sample_o       <= '0;
      fir_ch_o           <= 1'b0;
      valid_strobe_o     <= 1'b0;
      y_l_o              <= '0;
      y_r_o              <= '0;
      busy_o             <= 1'b0;
      overrun_cnt_o      <= '0;
      timeout_cnt_o      <= '0;
    end else begin
      fir_valid_strobe_o <= 1'b0;
      valid_strobe_o     <= 1'b0;

      if (valid_strobe_i && (state_reg != IDLE) && (overrun_cnt_o != CNT_MAX))
        overrun_cnt_o <= overrun_cnt_o + 1'b1;
      if (timeout_hit && (timeout_cnt_o != CNT_MAX))
        timeout_cnt_o <= timeout_cnt_o + 1'b1;

      case (state_reg)
        IDLE: begin
          if (valid_strobe_i) begin
            sample_r_reg <= sample_r_i;
            en_r_reg     <= ch_en_i[1];
            y_l_reg      <= '0;
            busy_o       <= 1'b1;
            if (ch_en_i[0]) begin
              state_reg          <= ISSUE_L;
              fir_valid_strobe_o <= 1'b1;
              fir_sample_o       <= sample_l_i;
              fir_ch_o           <= 1'b0;
            end else begin
              // An empty frame passes through ISSUE_R without issuing, giving it a two-cycle latency.
              state_reg <= ISSUE_R;
              if (ch_en_i[1]) begin
                fir_valid_strobe_o <= 1'b1;
                fir_sample_o       <= sample_r_i;
                fir_ch_o           <= 1'b1;
              end
            end
          end
        end
        ISSUE_L: begin
          wait_cnt_reg <= '0;
          state_reg    <= WAIT_L;
        end
        WAIT_L: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (wait_end) begin
            y_l_reg <= wait_result;
            if (en_r_reg) begin
              state_reg          <= ISSUE_R;
              fir_valid_strobe_o <= 1'b1;
              fir_sample_o       <= sample_r_reg;
              fir_ch_o           <= 1'b1;
            end else begin
              state_reg      <= OUT;
              valid_strobe_o <= 1'b1;
              y_l_o          <= wait_result;
              y_r_o          <= '0;
            end
          end
        end
        ISSUE_R: begin
          wait_cnt_reg <= '0;
          if (en_r_reg) begin
            state_reg <= WAIT_R;
          end else begin
            state_reg      <= OUT;
            valid_strobe_o <= 1'b1;
            y_l_o          <= '0;
            y_r_o          <= '0;
          end
        end
        WAIT_R: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (wait_end) begin
            state_reg      <= OUT;
            valid_strobe_o <= 1'b1;
            y_l_o          <= y_l_reg;
            y_r_o          <= wait_result;
          end
        end
        OUT: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_student_fir_ch_scheduler.sv
// Directed bench for the FIR channel scheduler: a delay-line FIR model that echoes the
// zero-extended sample, a vector table for whole frames and hand sequences for corner cases.
module tb_student_fir_ch_scheduler;

  localparam int DS = 16;
  localparam int YW = 27;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          valid_strobe_i = 1'b0;
  logic [DS-1:0] sample_l_i = '0;
  logic [DS-1:0] sample_r_i = '0;
  logic [1:0]    ch_en_i = '0;
  logic          fir_valid_strobe_o;
  logic [DS-1:0] fir_sample_o;
  logic          fir_ch_o;
  logic          fir_valid_strobe_i;
  logic [YW-1:0] fir_y_i;
  logic          valid_strobe_o;
  logic [YW-1:0] y_l_o;
  logic [YW-1:0] y_r_o;
  logic          busy_o;
  logic [CW-1:0] overrun_cnt_o;
  logic [CW-1:0] timeout_cnt_o;

  student_fir_ch_scheduler #(
    .DATA_SIZE(DS), .Y_WIDTH(YW), .TIMEOUT_CYCLES(16), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_strobe_i(valid_strobe_i), .sample_l_i(sample_l_i), .sample_r_i(sample_r_i),
    .ch_en_i(ch_en_i),
    .fir_valid_strobe_o(fir_valid_strobe_o), .fir_sample_o(fir_sample_o), .fir_ch_o(fir_ch_o),
    .fir_valid_strobe_i(fir_valid_strobe_i), .fir_y_i(fir_y_i),
    .valid_strobe_o(valid_strobe_o), .y_l_o(y_l_o), .y_r_o(y_r_o),
    .busy_o(busy_o), .overrun_cnt_o(overrun_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // FIR model: answers fir_delay cycles after each issue pulse when fir_resp_en is set.
  int            fir_delay = 5;
  logic          fir_resp_en = 1'b1;
  logic [63:0]   pipe_v = '0;
  logic [YW-1:0] pipe_d [64];

  always @(posedge clk_i) begin
    pipe_v    <= {pipe_v[62:0], fir_valid_strobe_o & fir_resp_en};
    pipe_d[0] <= {11'b0, fir_sample_o};
    for (int i = 1; i < 64; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign fir_valid_strobe_i = pipe_v[fir_delay-1];
  assign fir_y_i            = pipe_d[fir_delay-1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Results of the last run_frame call.
  int            r_vs_cyc;
  int            r_n_iss;
  int            r_iss_cyc0, r_iss_cyc1;
  logic          r_ch0, r_ch1;
  logic [DS-1:0] r_smp0, r_smp1;
  logic [YW-1:0] r_yl, r_yr;

  // Strobe a frame at cycle 0 and watch until valid_strobe_o (bounded to 200 cycles).
  task automatic run_frame(input logic [1:0] en, input logic [DS-1:0] l, input logic [DS-1:0] r,
                           input int second_at);
    @(posedge clk_i); #1;
    valid_strobe_i = 1'b1; ch_en_i = en; sample_l_i = l; sample_r_i = r;
    r_vs_cyc = -1; r_n_iss = 0; r_iss_cyc0 = -1; r_iss_cyc1 = -1;
    r_ch0 = 1'bx; r_ch1 = 1'bx; r_smp0 = 'x; r_smp1 = 'x; r_yl = 'x; r_yr = 'x;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (fir_valid_strobe_o) begin
        if (r_n_iss == 0) begin r_iss_cyc0 = k; r_ch0 = fir_ch_o; r_smp0 = fir_sample_o; end
        else if (r_n_iss == 1) begin r_iss_cyc1 = k; r_ch1 = fir_ch_o; r_smp1 = fir_sample_o; end
        r_n_iss++;
      end
      if (valid_strobe_o) begin
        r_vs_cyc = k; r_yl = y_l_o; r_yr = y_r_o;
        break;
      end
      @(posedge clk_i); #1;
      valid_strobe_i = ((k + 1) == second_at);
    end
    @(posedge clk_i); #1;
    valid_strobe_i = 1'b0;
    $display("frame en=%b L=%h R=%h: issues=%0d out@%0d y_l=%h y_r=%h", en, l, r, r_n_iss,
             r_vs_cyc, r_yl, r_yr);
  endtask

  task automatic count_strobes(input int ncyc, output int n);
    n = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk_i);
      if (valid_strobe_o) n++;
    end
  endtask

  typedef struct {
    logic [1:0]    en;
    logic [DS-1:0] l, r;
    int            exp_cyc;
    int            exp_iss;
    int            exp_iss1;
    logic          exp_ch0;
    logic [YW-1:0] exp_yl, exp_yr;
  } vec_t;

  vec_t vecs[5];
  int   n_extra;

  initial begin
    vecs[0] = '{2'b11, 16'h0100, 16'hFF00, 13, 2, 7, 1'b0, 27'h100,  27'hFF00};
    vecs[1] = '{2'b01, 16'h1234, 16'h5678,  7, 1, -1, 1'b0, 27'h1234, 27'h0};
    vecs[2] = '{2'b10, 16'h1111, 16'hABCD,  7, 1, -1, 1'b1, 27'h0,    27'hABCD};
    vecs[3] = '{2'b00, 16'h2222, 16'h3333,  2, 0, -1, 1'b0, 27'h0,    27'h0};
    vecs[4] = '{2'b11, 16'hFFFF, 16'h0001, 13, 2, 7, 1'b0, 27'hFFFF, 27'h1};

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst busy", busy_o, 0);
    check("rst fir_strobe", fir_valid_strobe_o, 0);
    check("rst fir_sample", fir_sample_o, 0);
    check("rst fir_ch", fir_ch_o, 0);
    check("rst valid", valid_strobe_o, 0);
    check("rst y_l", y_l_o, 0);
    check("rst y_r", y_r_o, 0);
    check("rst overrun", overrun_cnt_o, 0);
    check("rst timeout", timeout_cnt_o, 0);
    rst_ni = 1'b1;

    // Frame vectors with D=5
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].en, vecs[i].l, vecs[i].r, -1);
      check($sformatf("v%0d out cycle", i), r_vs_cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d issues", i), r_n_iss, vecs[i].exp_iss);
      check($sformatf("v%0d y_l", i), r_yl, vecs[i].exp_yl);
      check($sformatf("v%0d y_r", i), r_yr, vecs[i].exp_yr);
      if (vecs[i].exp_iss > 0) begin
        check($sformatf("v%0d issue0 cycle", i), r_iss_cyc0, 1);
        check($sformatf("v%0d issue0 ch", i), r_ch0, vecs[i].exp_ch0);
        check($sformatf("v%0d issue0 sample", i), r_smp0, vecs[i].exp_ch0 ? vecs[i].r : vecs[i].l);
      end
      if (vecs[i].exp_iss > 1) begin
        check($sformatf("v%0d issue1 cycle", i), r_iss_cyc1, vecs[i].exp_iss1);
        check($sformatf("v%0d issue1 ch", i), r_ch1, 1);
        check($sformatf("v%0d issue1 sample", i), r_smp1, vecs[i].r);
      end
    end

    // Overrun: second strobe 3 cycles into the frame
    run_frame(2'b11, 16'h0F0F, 16'hF0F0, 3);
    check("ovr out cycle", r_vs_cyc, 13);
    check("ovr y_l", r_yl, 27'h0F0F);
    check("ovr y_r", r_yr, 27'hF0F0);
    count_strobes(20, n_extra);
    check("ovr no 2nd frame", n_extra, 0);
    check("ovr count", overrun_cnt_o, 1);

    // Hung FIR: both channels time out
    fir_resp_en = 1'b0;
    run_frame(2'b11, 16'hAAAA, 16'h5555, -1);
    check("to out cycle", r_vs_cyc, 35);
    check("to issue1 cycle", r_iss_cyc1, 18);
    check("to y_l", r_yl, 0);
    check("to y_r", r_yr, 0);
    check("to count", timeout_cnt_o, 2);

    // FIR done lands exactly on the expiry cycle
    fir_resp_en = 1'b1;
    fir_delay   = 16;
    run_frame(2'b11, 16'h1357, 16'h2468, -1);
    check("edge out cycle", r_vs_cyc, 35);
    check("edge y_l", r_yl, 27'h1357);
    check("edge y_r", r_yr, 27'h2468);
    check("edge timeout unchanged", timeout_cnt_o, 2);
    fir_delay = 5;

    // Reset while in WAIT_R
    @(posedge clk_i); #1;
    valid_strobe_i = 1'b1; ch_en_i = 2'b11; sample_l_i = 16'h0A0A; sample_r_i = 16'h0B0B;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i); #1;
      valid_strobe_i = 1'b0;
    end
    check("wr busy before rst", busy_o, 1);
    check("wr ch before rst", fir_ch_o, 1);
    rst_ni = 1'b0;
    #1;
    check("wr rst busy", busy_o, 0);
    check("wr rst fir_ch", fir_ch_o, 0);
    check("wr rst fir_sample", fir_sample_o, 0);
    check("wr rst y_l", y_l_o, 0);
    check("wr rst y_r", y_r_o, 0);
    check("wr rst overrun", overrun_cnt_o, 0);
    check("wr rst timeout", timeout_cnt_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    count_strobes(20, n_extra);
    check("wr no strobe", n_extra, 0);
    run_frame(2'b11, 16'h0C0C, 16'h0D0D, -1);
    check("post rst out cycle", r_vs_cyc, 13);
    check("post rst y_l", r_yl, 27'h0C0C);
    check("post rst y_r", r_yr, 27'h0D0D);

    // Overrun counter saturation: strobe every cycle for 400 cycles
    @(posedge clk_i); #1;
    valid_strobe_i = 1'b1; ch_en_i = 2'b11;
    repeat (400) @(posedge clk_i);
    #1;
    valid_strobe_i = 1'b0;
    $display("saturation run: overrun_cnt=%0h", overrun_cnt_o);
    check("ovr saturated", overrun_cnt_o, 8'hFF);
    for (int k = 0; k < 100 && busy_o; k++) @(negedge clk_i);
    check("idle after burst", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
